// File: rtl/branch_sequencer_if.sv
// Decoder-to-sequencer instruction handshake: one decoded control-flow instruction per accept.
interface branch_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  opcode;
  logic [3:0]  cond;
  logic [31:0] imm;
  logic [31:0] reg_val;
  logic        nop_en;
  logic        bkpt_en;

  modport master (
    output instr_valid, opcode, cond, imm, reg_val, nop_en, bkpt_en,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, opcode, cond, imm, reg_val, nop_en, bkpt_en,
    output instr_ready
  );
endinterface

// File: rtl/branch_sequencer.sv
// Branch path sequencer: owns pc/lr, resolves control flow, inserts a flush window
// after taken branches and parks in HALT on breakpoints until debug resume/step.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  branch_sequencer_if.slave   ib,
  input  logic                dbg_resume,
  input  logic                dbg_step,
  output logic [31:0]         pc,
  output logic [31:0]         lr,
  output logic                fetch_en,
  output logic                flush,
  output logic                halted,
  output logic [7:0]          bkpt_count
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {RUN, FLUSH, HALT, STEP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   flush_cnt;

  logic               issue_c;
  logic               accept_c;
  logic               cond_true_c;
  logic               taken_c;
  logic               link_c;
  logic [31:0]        pc_plus4_c;
  logic [31:0]        npc_c;

  // Instruction issue is only open in RUN/STEP and held closed while reset is low.
  assign issue_c        = reset && ((state == RUN) || (state == STEP));
  assign ib.instr_ready = issue_c;
  assign fetch_en       = issue_c;
  assign halted         = (state == HALT);
  assign accept_c       = ib.instr_valid && issue_c;

  // Resolve next pc, link write and taken for the instruction on the bus.
  always_comb begin
    pc_plus4_c  = pc + 32'd4;
    npc_c       = pc_plus4_c;
    taken_c     = 1'b0;
    link_c      = 1'b0;
    cond_true_c = 1'b0;

    case (ib.cond)
      4'b0000: cond_true_c = (ib.reg_val == 32'd0);
      4'b0001: cond_true_c = (ib.reg_val != 32'd0);
      4'b1010: cond_true_c = ($signed(ib.reg_val) > 32'sd0);
      4'b1011: cond_true_c = ($signed(ib.reg_val) < 32'sd0);
      default: cond_true_c = 1'b0;
    endcase

    if (!ib.nop_en) begin
      case (ib.opcode)
        2'b00: begin
          npc_c   = pc + ib.imm;
          taken_c = 1'b1;
        end
        2'b01: begin
          npc_c   = pc + ib.imm;
          taken_c = 1'b1;
          link_c  = 1'b1;
        end
        2'b10: begin
          npc_c   = {ib.reg_val[31:1], 1'b0};
          taken_c = 1'b1;
          link_c  = 1'b1;
        end
        default: begin
          if (ib.cond == 4'b1110) begin
            npc_c   = {ib.reg_val[31:1], 1'b0};
            taken_c = 1'b1;
          end else if (cond_true_c) begin
            npc_c   = pc + ib.imm;
            taken_c = 1'b1;
          end
        end
      endcase
    end
  end

  // State machine with registered pc/lr/flush/breakpoint count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      flush_cnt  <= '0;
      pc         <= RESET_PC;
      lr         <= 32'd0;
      flush      <= 1'b0;
      bkpt_count <= 8'd0;
    end else begin
      flush <= 1'b0;
      case (state)
        RUN, STEP: begin
          if (accept_c) begin
            if (ib.bkpt_en) begin
              if (bkpt_count != 8'hFF) bkpt_count <= bkpt_count + 8'd1;
              state <= HALT;
            end else begin
              pc    <= npc_c;
              flush <= taken_c;
              if (link_c) lr <= pc_plus4_c;
              // A single step always returns to HALT, bypassing the flush window.
              if (state == STEP) begin
                state <= HALT;
              end else if (taken_c) begin
                state     <= FLUSH;
                flush_cnt <= CNT_W'(FLUSH_CYCLES);
              end
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - CNT_W'(1);
          if (flush_cnt <= CNT_W'(1)) state <= RUN;
        end
        HALT: begin
          if (dbg_resume) begin
            pc    <= pc_plus4_c;
            state <= RUN;
          end else if (dbg_step) begin
            state <= STEP;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: vector table for single accepts plus
// hand sequences for breakpoint/debug, reset during flush/halt and saturation.
module tb_branch_sequencer;

  logic        clk;
  logic        reset;
  logic        dbg_resume;
  logic        dbg_step;
  logic [31:0] pc;
  logic [31:0] lr;
  logic        fetch_en;
  logic        flush;
  logic        halted;
  logic [7:0]  bkpt_count;

  int n_tests;
  int n_fail;

  branch_sequencer_if bif ();

  branch_sequencer #(
    .RESET_PC     (32'h0000_0100),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ib         (bif.slave),
    .dbg_resume (dbg_resume),
    .dbg_step   (dbg_step),
    .pc         (pc),
    .lr         (lr),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .halted     (halted),
    .bkpt_count (bkpt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        nop;
    logic [1:0]  opcode;
    logic [3:0]  cond;
    logic [31:0] imm;
    logic [31:0] reg_val;
    logic [31:0] exp_pc;
    logic [31:0] exp_lr;
    logic        exp_taken;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bif.instr_valid = 1'b0;
    bif.nop_en      = 1'b0;
    bif.bkpt_en     = 1'b0;
    bif.opcode      = 2'b00;
    bif.cond        = 4'b0000;
    bif.imm         = 32'd0;
    bif.reg_val     = 32'd0;
  endtask

  // Drives one accept from RUN and checks result plus the flush window shape.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    bif.instr_valid = 1'b1;
    bif.nop_en      = v.nop;
    bif.opcode      = v.opcode;
    bif.cond        = v.cond;
    bif.imm         = v.imm;
    bif.reg_val     = v.reg_val;
    @(posedge clk); #1;
    idle_bus();
    chk({tag, "_pc"}, pc, v.exp_pc);
    chk({tag, "_lr"}, lr, v.exp_lr);
    chk({tag, "_flush"}, 32'(flush), 32'(v.exp_taken));
    chk({tag, "_ready"}, 32'(bif.instr_ready), 32'(!v.exp_taken));
    if (v.exp_taken) begin
      @(posedge clk); #1;
      chk({tag, "_ready_w2"}, 32'(bif.instr_ready), 32'd0);
      chk({tag, "_flush_off"}, 32'(flush), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_ready_back"}, 32'(bif.instr_ready), 32'd1);
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    dbg_resume = 1'b0;
    dbg_step   = 1'b0;
    idle_bus();

    //            nop opc    cond     imm           reg_val       exp_pc        exp_lr        taken
    vecs[0]  = '{1'b1, 2'b00, 4'b0000, 32'h0,        32'h0,        32'h0000_0104, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b00, 4'b0000, 32'h0000_00FC, 32'h0,       32'h0000_0200, 32'h0,        1'b1};
    vecs[2]  = '{1'b0, 2'b01, 4'b0000, 32'h0000_0040, 32'h0,       32'h0000_0240, 32'h0000_0204, 1'b1};
    vecs[3]  = '{1'b0, 2'b11, 4'b1010, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0244, 32'h0000_0204, 1'b0};
    vecs[4]  = '{1'b0, 2'b11, 4'b1010, 32'h0000_0010, 32'h5,       32'h0000_0254, 32'h0000_0204, 1'b1};
    vecs[5]  = '{1'b0, 2'b11, 4'b0110, 32'h0000_0010, 32'h0,       32'h0000_0258, 32'h0000_0204, 1'b0};
    vecs[6]  = '{1'b0, 2'b11, 4'b0000, 32'h0000_0008, 32'h0,       32'h0000_0260, 32'h0000_0204, 1'b1};
    vecs[7]  = '{1'b0, 2'b11, 4'b0001, 32'h0000_0008, 32'h0,       32'h0000_0264, 32'h0000_0204, 1'b0};
    vecs[8]  = '{1'b0, 2'b11, 4'b1011, 32'hFFFF_FFFC, 32'h8000_0000, 32'h0000_0260, 32'h0000_0204, 1'b1};
    vecs[9]  = '{1'b0, 2'b11, 4'b1110, 32'h0000_0040, 32'h0000_0011, 32'h0000_0010, 32'h0000_0204, 1'b1};
    vecs[10] = '{1'b0, 2'b10, 4'b0000, 32'h0000_0040, 32'h0000_0301, 32'h0000_0300, 32'h0000_0014, 1'b1};
    vecs[11] = '{1'b0, 2'b11, 4'b0001, 32'hFFFF_FFF0, 32'h1,       32'h0000_02F0, 32'h0000_0014, 1'b1};
    vecs[12] = '{1'b1, 2'b01, 4'b0000, 32'h0000_0040, 32'h0,       32'h0000_02F4, 32'h0000_0014, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 4'b0000, 32'hFFFF_FD08, 32'h0,       32'hFFFF_FFFC, 32'h0000_0014, 1'b1};
    vecs[14] = '{1'b1, 2'b00, 4'b0000, 32'h0,        32'h0,        32'h0000_0000, 32'h0000_0014, 1'b0};
    vecs[15] = '{1'b0, 2'b01, 4'b0000, 32'h0000_0050, 32'h0,       32'h0000_0050, 32'h0000_0004, 1'b1};

    // Reset held, then released mid-cycle.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0000_0100);
    chk("rst_lr", lr, 32'h0);
    chk("rst_ready", 32'(bif.instr_ready), 32'd0);
    chk("rst_fetch", 32'(fetch_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_bkpt", 32'(bkpt_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ready", 32'(bif.instr_ready), 32'd1);
    chk("rel_fetch", 32'(fetch_en), 32'd1);
    chk("rel_flush", 32'(flush), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Breakpoint at 0x50, then single-step a B -8, then resume+step together.
    bif.instr_valid = 1'b1;
    bif.bkpt_en     = 1'b1;
    bif.opcode      = 2'b00;
    bif.imm         = 32'h0000_0100;
    @(posedge clk); #1;
    idle_bus();
    chk("bkpt_pc", pc, 32'h0000_0050);
    chk("bkpt_halted", 32'(halted), 32'd1);
    chk("bkpt_count1", 32'(bkpt_count), 32'd1);
    chk("bkpt_ready", 32'(bif.instr_ready), 32'd0);
    chk("bkpt_fetch", 32'(fetch_en), 32'd0);
    chk("bkpt_flush", 32'(flush), 32'd0);
    dbg_step = 1'b1;
    @(posedge clk); #1;
    dbg_step = 1'b0;
    chk("step_halted", 32'(halted), 32'd0);
    chk("step_ready", 32'(bif.instr_ready), 32'd1);
    chk("step_pc", pc, 32'h0000_0050);
    bif.instr_valid = 1'b1;
    bif.opcode      = 2'b00;
    bif.imm         = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    idle_bus();
    chk("stepb_pc", pc, 32'h0000_0048);
    chk("stepb_flush", 32'(flush), 32'd1);
    chk("stepb_halted", 32'(halted), 32'd1);
    dbg_resume = 1'b1;
    dbg_step   = 1'b1;
    @(posedge clk); #1;
    dbg_resume = 1'b0;
    dbg_step   = 1'b0;
    chk("resume_pc", pc, 32'h0000_004C);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_flush", 32'(flush), 32'd0);
    chk("resume_ready", 32'(bif.instr_ready), 32'd1);

    // Debug controls have no effect outside HALT.
    dbg_resume = 1'b1;
    dbg_step   = 1'b1;
    @(posedge clk); #1;
    dbg_resume = 1'b0;
    dbg_step   = 1'b0;
    chk("dbg_run_pc", pc, 32'h0000_004C);
    chk("dbg_run_halted", 32'(halted), 32'd0);

    // Asynchronous reset while in the flush window.
    bif.instr_valid = 1'b1;
    bif.imm         = 32'h0000_0010;
    @(posedge clk); #1;
    idle_bus();
    chk("fl_pc", pc, 32'h0000_005C);
    chk("fl_flush", 32'(flush), 32'd1);
    reset = 1'b0;
    #1;
    chk("flrst_pc", pc, 32'h0000_0100);
    chk("flrst_lr", lr, 32'h0);
    chk("flrst_flush", 32'(flush), 32'd0);
    chk("flrst_ready", 32'(bif.instr_ready), 32'd0);
    chk("flrst_bkpt", 32'(bkpt_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("flrel_ready", 32'(bif.instr_ready), 32'd1);
    chk("flrel_pc", pc, 32'h0000_0100);

    // 256 breakpoints, each resumed; count saturates, pc steps by 4 per resume.
    for (int i = 0; i < 256; i++) begin
      bif.instr_valid = 1'b1;
      bif.bkpt_en     = 1'b1;
      @(posedge clk); #1;
      idle_bus();
      dbg_resume = 1'b1;
      @(posedge clk); #1;
      dbg_resume = 1'b0;
      if (i == 254) chk("bkpt_255", 32'(bkpt_count), 32'd255);
    end
    chk("bkpt_sat", 32'(bkpt_count), 32'd255);
    chk("bkpt_sat_pc", pc, 32'h0000_0500);

    // Reset while halted with a step request pending.
    bif.instr_valid = 1'b1;
    bif.bkpt_en     = 1'b1;
    @(posedge clk); #1;
    idle_bus();
    chk("hrst_pre", 32'(halted), 32'd1);
    dbg_step = 1'b1;
    reset    = 1'b0;
    #1;
    chk("hrst_halted", 32'(halted), 32'd0);
    chk("hrst_pc", pc, 32'h0000_0100);
    chk("hrst_bkpt", 32'(bkpt_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    dbg_step = 1'b0;
    chk("hrel_halted", 32'(halted), 32'd0);
    chk("hrel_ready", 32'(bif.instr_ready), 32'd1);
    chk("hrel_pc", pc, 32'h0000_0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
